ssd_capture: RTL and testbench
==============================

// Module: ssd_capture
// PURPOSE
//  Receive-side monitor for the 2-digit multiplexed seven-segment bus (seg gfedcba + digit select).
//  Resynchronises the bus and waits for each digit phase to settle.
//  Decodes each settled pattern back to BCD and commits ones/tens pairs as digit and binary outputs.
//  Used as an on-chip self-check / loopback reader of the display path.
// PARAMETERS
//  SETTLE_CYCLES   1000       consecutive stable sync'd cycles required before a phase is sampled (>=2)
//  TIMEOUT_CYCLES  4000000    cycles without a digit-select toggle before valid is dropped
// PORTS
//  clk           in   1  system clock (125 MHz)
//  rst           in   1  reset, synchronous, active-high
//  seg_in        in   7  segment bus, bit6=g .. bit0=a, 1 = segment lit
//  digit_sel_in  in   1  digit select: 0 = ones digit shown, 1 = tens digit shown
//  digit0        out  4  committed ones digit, BCD
//  digit1        out  4  committed tens digit, BCD
//  value         out  7  digit1*10 + digit0, binary 0..99
//  valid         out  1  a pair has been committed and the bus is not timed out
//  update        out  1  one-cycle pulse when a pair is committed
//  changed       out  1  one-cycle pulse with update when the committed value differs from the previous one
//  code_err      out  1  one-cycle pulse when a settled phase carries an undecodable pattern
//  err_cnt       out  8  count of code_err pulses, saturates at 255
// BEHAVIOUR
//  - Reset: all outputs 0; FSM -> WAIT_EDGE; sync flops, settle/timeout counters and pair flag cleared.
//  - Input sync: 2-flop synchroniser on seg_in and digit_sel_in; everything below uses sync'd values only.
//  - Decode table (gfedcba):
//    0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110,
//    5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
//    Any other pattern, including 1111110, is an error.
//  - FSM:
//    WAIT_EDGE: ignore bus until first sel toggle -> SETTLE.
//    SETTLE: stable counter cleared on any seg or sel change; when it reaches SETTLE_CYCLES -> sample -> CAPTURED.
//    CAPTURED: hold until sel toggles -> SETTLE.
//    A sel toggle while in SETTLE discards the phase and restarts SETTLE; seg changes only clear the counter.
//  - Sample, ones phase (sel=0): valid code -> latch ones, set pair flag; bad code -> code_err, clear pair flag.
//  - Sample, tens phase (sel=1): valid code and pair flag set -> commit.
//    Commit = digit0/digit1/value written atomically, update=1, changed=1 if value differs, valid=1.
//    Bad code -> code_err, no commit. Pair flag is cleared after every tens sample.
//  - A discarded ones phase clears the pair flag; a pair is only ones-captured immediately followed by tens-captured.
//  - Latency: commit pulse 2 (sync) + SETTLE_CYCLES + 1 cycles after the last tens-phase bus change.
//  - Timeout: counter clears on every sel toggle.
//    At TIMEOUT_CYCLES, valid -> 0, FSM -> WAIT_EDGE, pair flag cleared; digits/value hold last commit.
//    The counter saturates (no wrap).
//  - changed on the first commit after reset: compares against reset value 0 (first commit of 00 -> changed=0).
//  - err_cnt: +1 per code_err, holds at 255. update and code_err never assert in the same cycle.
//  - rst mid-operation: same as power-on reset; first update needs a full new pair after the first toggle.
// TESTING (SETTLE_CYCLES=8, TIMEOUT_CYCLES=200)
//  1 Reset: rst 3 cycles, bus idle -> all outputs 0, no update for 100 cycles without a toggle.
//  2 Normal pair: sel=0, seg=0000111 for 20 cycles; sel=1, seg=1100110 for 20 cycles; preceded by one toggle.
//    -> update+changed, digit0=7, digit1=4, value=47, valid=1.
//  3 Glitch: after case 2, sel=0 for 5 cycles, then sel=1 (tens=9) for 20 cycles -> no update, outputs stay 47.
//  4 Bad code: ones=3 then tens=1111110 -> code_err 1 cycle, err_cnt=1, no update, value stays 47.
//  5 Repeat/timeout: same pair 47 twice -> update without changed; hold sel 250 cycles -> valid=0, value=47.
//    Resume with pair 0/5 -> valid=1, value=50, changed=1.
//  6 Reset mid-settle: rst during tens SETTLE -> outputs 0; err_cnt saturation: 260 bad phases -> err_cnt=255.

Source files
------------

// File: rtl/ssd_capture_if.sv
// ssd_capture_if
//   Bundles the multiplexed seven-segment bus that feeds the capture block
//   and the decoded result that it produces.
//
//   Signals
//     seg_in        7  segment bus, bit6=g .. bit0=a, 1 = segment lit
//     digit_sel_in  1  0 = ones digit on the bus, 1 = tens digit on the bus
//     digit0        4  committed ones digit (BCD)
//     digit1        4  committed tens digit (BCD)
//     value         7  digit1*10 + digit0
//     valid         1  a pair is committed and the bus has not timed out
//     update        1  strobe: a pair was committed this cycle
//     changed       1  strobe: qualifies update, committed value differs
//     code_err      1  strobe: a settled phase held an undecodable pattern
//     err_cnt       8  saturating count of code_err strobes
//     state_dbg     2  capture FSM state, for observation only
//
//   Handshake: there is no backpressure. update, changed and code_err are
//   single-cycle strobes that the consumer must sample every cycle.
//   digit0/digit1/value change only in the cycle where update is high and
//   are stable at all other times; valid is a level.
//
//   Modports
//     master : drives the segment bus, observes the result (bus source / bench)
//     slave  : receives the segment bus, drives the result (ssd_capture)

interface ssd_capture_if;
    logic [6:0] seg_in;
    logic       digit_sel_in;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [6:0] value;
    logic       valid;
    logic       update;
    logic       changed;
    logic       code_err;
    logic [7:0] err_cnt;
    logic [1:0] state_dbg;

    modport master (
        output seg_in,
        output digit_sel_in,
        input  digit0,
        input  digit1,
        input  value,
        input  valid,
        input  update,
        input  changed,
        input  code_err,
        input  err_cnt,
        input  state_dbg
    );

    modport slave (
        input  seg_in,
        input  digit_sel_in,
        output digit0,
        output digit1,
        output value,
        output valid,
        output update,
        output changed,
        output code_err,
        output err_cnt,
        output state_dbg
    );
endinterface

// File: rtl/ssd_capture.sv
// ssd_capture
//   Receive-side monitor for a 2-digit multiplexed seven-segment bus.
//   The bus is resynchronised, each digit phase is allowed to settle for
//   SETTLE_CYCLES stable cycles, the settled pattern is decoded back to BCD
//   and a ones phase immediately followed by a tens phase is committed as a
//   pair. Used as a loopback reader of the display path.
//
//   Parameters
//     SETTLE_CYCLES   stable synchronised cycles required before sampling (>=2)
//     TIMEOUT_CYCLES  cycles without a digit-select toggle before valid drops
//
//   Ports
//     clk   in   system clock
//     rst   in   synchronous, active-high reset
//     bus   slave modport of ssd_capture_if (segment bus in, results out)

module ssd_capture #(
    parameter int SETTLE_CYCLES  = 1000,
    parameter int TIMEOUT_CYCLES = 4000000
) (
    input  logic          clk,
    input  logic          rst,
    ssd_capture_if.slave  bus
);

    localparam int SC_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    // The stable counter is cleared in the cycle a change is seen, so the
    // phase is sampled when it shows SETTLE_CYCLES-1; this gives a commit
    // 2 + SETTLE_CYCLES + 1 cycles after the last bus change.
    localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);
    localparam logic [TO_W-1:0] TIMEOUT_MAX = TO_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        WAIT_EDGE = 2'd0,
        SETTLE    = 2'd1,
        CAPTURED  = 2'd2
    } state_t;

    // Returns {ok, bcd}; ok=0 for anything outside the 0..9 glyph table.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] r;
        r = 5'b0_0000;
        case (seg)
            7'b0111111: r = {1'b1, 4'd0};
            7'b0000110: r = {1'b1, 4'd1};
            7'b1011011: r = {1'b1, 4'd2};
            7'b1001111: r = {1'b1, 4'd3};
            7'b1100110: r = {1'b1, 4'd4};
            7'b1101101: r = {1'b1, 4'd5};
            7'b1111101: r = {1'b1, 4'd6};
            7'b0000111: r = {1'b1, 4'd7};
            7'b1111111: r = {1'b1, 4'd8};
            7'b1101111: r = {1'b1, 4'd9};
            default:    r = 5'b0_0000;
        endcase
        return r;
    endfunction

    // Synchroniser stages plus one history stage for change detection.
    logic [6:0] seg_s1, seg_s2, seg_q;
    logic       sel_s1, sel_s2, sel_q;

    state_t            state_q, state_n;
    logic [SC_W-1:0]   stable_cnt_q, stable_cnt_n;
    logic [TO_W-1:0]   tmo_cnt_q;
    logic              pair_q, pair_n;
    logic [3:0]        ones_q;

    logic [3:0] digit0_q, digit1_q;
    logic [6:0] value_q;
    logic       valid_q, update_q, changed_q, code_err_q;
    logic [7:0] err_cnt_q;

    logic       sel_tog, seg_chg, tmo_hit;
    logic       do_sample, discard;
    logic       commit, err_pulse, ones_load;
    logic [4:0] dec;
    logic       dec_ok;
    logic [3:0] dec_val;
    logic [6:0] new_value;

    assign sel_tog   = sel_s2 ^ sel_q;
    assign seg_chg   = (seg_s2 != seg_q);
    // A toggle in the same cycle restarts the timeout window, so it wins.
    assign tmo_hit   = (tmo_cnt_q == TIMEOUT_MAX) && !sel_tog;

    assign dec       = decode_seg(seg_s2);
    assign dec_ok    = dec[4];
    assign dec_val   = dec[3:0];
    assign new_value = 7'(dec_val) * 7'd10 + 7'(ones_q);

    // Next-state and phase bookkeeping.
    always_comb begin
        state_n      = state_q;
        stable_cnt_n = stable_cnt_q;
        do_sample    = 1'b0;
        discard      = 1'b0;

        if (tmo_hit) begin
            state_n = WAIT_EDGE;
        end else begin
            case (state_q)
                WAIT_EDGE: begin
                    if (sel_tog) begin
                        state_n      = SETTLE;
                        stable_cnt_n = '0;
                    end
                end
                SETTLE: begin
                    if (sel_tog) begin
                        // Phase ended before it settled: drop it, start the new one.
                        discard      = 1'b1;
                        stable_cnt_n = '0;
                    end else if (seg_chg) begin
                        stable_cnt_n = '0;
                    end else if (stable_cnt_q == SETTLE_LAST) begin
                        do_sample = 1'b1;
                        state_n   = CAPTURED;
                    end else begin
                        stable_cnt_n = stable_cnt_q + 1'b1;
                    end
                end
                CAPTURED: begin
                    if (sel_tog) begin
                        state_n      = SETTLE;
                        stable_cnt_n = '0;
                    end
                end
                default: begin
                    state_n = WAIT_EDGE;
                end
            endcase
        end
    end

    // Sample outcomes. sel_s2 is the phase being sampled (0 = ones, 1 = tens).
    always_comb begin
        commit    = 1'b0;
        err_pulse = 1'b0;
        ones_load = 1'b0;
        pair_n    = pair_q;

        if (tmo_hit || discard) begin
            pair_n = 1'b0;
        end else if (do_sample) begin
            if (!dec_ok) begin
                err_pulse = 1'b1;
                pair_n    = 1'b0;
            end else if (!sel_s2) begin
                ones_load = 1'b1;
                pair_n    = 1'b1;
            end else begin
                commit = pair_q;
                pair_n = 1'b0;
            end
            // A bad tens pattern also lands here with pair_n already 0.
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_s1       <= '0;
            seg_s2       <= '0;
            seg_q        <= '0;
            sel_s1       <= 1'b0;
            sel_s2       <= 1'b0;
            sel_q        <= 1'b0;
            state_q      <= WAIT_EDGE;
            stable_cnt_q <= '0;
            tmo_cnt_q    <= '0;
            pair_q       <= 1'b0;
            ones_q       <= '0;
            digit0_q     <= '0;
            digit1_q     <= '0;
            value_q      <= '0;
            valid_q      <= 1'b0;
            update_q     <= 1'b0;
            changed_q    <= 1'b0;
            code_err_q   <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            seg_s1       <= bus.seg_in;
            seg_s2       <= seg_s1;
            seg_q        <= seg_s2;
            sel_s1       <= bus.digit_sel_in;
            sel_s2       <= sel_s1;
            sel_q        <= sel_s2;
            state_q      <= state_n;
            stable_cnt_q <= stable_cnt_n;
            pair_q       <= pair_n;

            if (sel_tog) begin
                tmo_cnt_q <= '0;
            end else if (tmo_cnt_q != TIMEOUT_MAX) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end

            if (ones_load) begin
                ones_q <= dec_val;
            end

            update_q   <= commit;
            changed_q  <= commit && (new_value != value_q);
            code_err_q <= err_pulse;

            // Digits and value are written together so a reader never sees a mixed pair.
            if (commit) begin
                digit0_q <= ones_q;
                digit1_q <= dec_val;
                value_q  <= new_value;
            end

            if (tmo_hit) begin
                valid_q <= 1'b0;
            end else if (commit) begin
                valid_q <= 1'b1;
            end

            if (err_pulse && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end

    assign bus.digit0    = digit0_q;
    assign bus.digit1    = digit1_q;
    assign bus.value     = value_q;
    assign bus.valid     = valid_q;
    assign bus.update    = update_q;
    assign bus.changed   = changed_q;
    assign bus.code_err  = code_err_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_ssd_capture.sv
// tb_ssd_capture
//   Drives the segment bus as a sequence of digit phases. Every phase toggles
//   digit select; a phase may open with a short glitch pattern before its
//   main pattern. A phase-level reference model predicts the strobes each
//   phase produces and the resulting output levels.

module tb_ssd_capture;

    localparam int SETTLE  = 8;
    localparam int TIMEOUT = 200;
    localparam int W       = 18;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ssd_capture_if bus ();

    ssd_capture #(
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- scoreboard state ----------------
    int              n_checks = 0;
    int              n_fail   = 0;
    logic [W-1:0]    exp_q[$];
    int              last_update_cyc = 0;
    int              last_change_cyc = 0;
    logic            cur_sel = 1'b0;

    // Reference model state (phase level).
    int   m_d0, m_d1, m_val, m_err;
    logic m_valid, m_pair;
    int   m_ones;

    logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                 7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                 7'b1111111, 7'b1101111};

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] ev(input logic ce, input logic up, input logic ch,
                                        input int d1, input int d0, input int v);
        return {ce, up, ch, 4'(d1), 4'(d0), 7'(v)};
    endfunction

    task automatic tb_decode(input logic [6:0] seg, output logic ok, output int d);
        ok = 1'b0;
        d  = 0;
        for (int i = 0; i < 10; i++) begin
            if (seg_tab[i] == seg) begin
                ok = 1'b1;
                d  = i;
            end
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] act;
        if (!rst && (bus.update || bus.code_err || bus.changed)) begin
            if (bus.update) last_update_cyc = cyc;
            check_val("update_code_err_overlap", int'(bus.update & bus.code_err), 0);
            act = bus.update ? ev(bus.code_err, bus.update, bus.changed,
                                  int'(bus.digit1), int'(bus.digit0), int'(bus.value))
                             : ev(bus.code_err, bus.update, bus.changed, 0, 0, 0);
            if (exp_q.size() == 0) check_val("unexpected_event", int'(act), 0);
            else                   check_val("event", int'(act), int'(exp_q.pop_front()));
        end
    end

    task automatic check_levels(input string tag);
        check_val({tag, "_pending"}, exp_q.size(), 0);
        check_val({tag, "_digit0"},  int'(bus.digit0),  m_d0);
        check_val({tag, "_digit1"},  int'(bus.digit1),  m_d1);
        check_val({tag, "_value"},   int'(bus.value),   m_val);
        check_val({tag, "_valid"},   int'(bus.valid),   int'(m_valid));
        check_val({tag, "_err_cnt"}, int'(bus.err_cnt), m_err);
    endtask

    // ---------------- reference model ----------------
    // A phase is sampled when its final pattern lasts more than SETTLE cycles;
    // the bus times out when a phase lasts more than TIMEOUT cycles. Stimulus
    // keeps phase lengths well clear of both thresholds.
    task automatic model_phase(input logic sel, input logic [6:0] seg,
                               input int total, input int main_len);
        logic ok;
        int   d, v;
        if (main_len > SETTLE) begin
            tb_decode(seg, ok, d);
            if (!ok) begin
                exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 0, 0, 0));
                if (m_err < 255) m_err++;
                m_pair = 1'b0;
            end else if (!sel) begin
                m_ones = d;
                m_pair = 1'b1;
            end else begin
                if (m_pair) begin
                    v = d * 10 + m_ones;
                    exp_q.push_back(ev(1'b0, 1'b1, v != m_val, d, m_ones, v));
                    m_d0 = m_ones;
                    m_d1 = d;
                    m_val = v;
                    m_valid = 1'b1;
                end
                m_pair = 1'b0;
            end
        end else begin
            m_pair = 1'b0;
        end
        if (total > TIMEOUT) begin
            m_valid = 1'b0;
            m_pair  = 1'b0;
        end
    endtask

    // ---------------- drivers ----------------
    task automatic reset_dut(input string tag);
        @(negedge clk);
        rst              = 1'b1;
        bus.seg_in       = 7'd0;
        bus.digit_sel_in = 1'b0;
        cur_sel          = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        m_d0 = 0; m_d1 = 0; m_val = 0; m_err = 0;
        m_valid = 1'b0; m_pair = 1'b0; m_ones = 0;
        check_levels(tag);
    endtask

    task automatic drive_phase(input logic [6:0] seg, input int len,
                               input logic [6:0] pre_seg, input int pre_len);
        logic sel;
        sel     = ~cur_sel;
        cur_sel = sel;
        model_phase(sel, seg, pre_len + len, len);
        for (int i = 0; i < pre_len + len; i++) begin
            @(negedge clk);
            bus.digit_sel_in = sel;
            bus.seg_in       = (i < pre_len) ? pre_seg : seg;
            if (i == pre_len) last_change_cyc = cyc;
        end
        if (len >= SETTLE + 5) check_levels("phase");
    endtask

    task automatic phase(input int digit, input int len);
        drive_phase(seg_tab[digit], len, 7'd0, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int         r, len, pre_len, dgt;
        logic [6:0] seg, pre_seg;

        bus.seg_in       = 7'd0;
        bus.digit_sel_in = 1'b0;

        // 1: reset, idle bus, nothing may happen without a toggle.
        reset_dut("reset");
        repeat (100) @(negedge clk);
        check_levels("idle");

        // 2: one priming toggle, then ones=7, tens=4.
        drive_phase(7'd0, 4, 7'd0, 0);
        phase(7, 20);
        phase(4, 20);
        check_val("commit_latency", last_update_cyc - last_change_cyc, SETTLE + 3);

        // 3: short ones phase is discarded, so tens=9 must not commit.
        phase(7, 5);
        phase(9, 20);

        // 4: undecodable tens pattern.
        phase(3, 20);
        drive_phase(7'b1111110, 20, 7'd0, 0);

        // 5: repeat of 47 commits without changed; long tens phase times out.
        phase(7, 20);
        phase(4, 20);
        phase(7, 20);
        phase(4, 250);
        phase(0, 20);
        phase(5, 20);

        // Glitch at the start of a phase only restarts settling.
        drive_phase(seg_tab[1], 20, 7'b1110000, 3);
        drive_phase(seg_tab[6], 20, seg_tab[2], SETTLE - 2);

        // Random phases.
        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 99);
            if (r < 12)      len = $urandom_range(1, SETTLE - 2);
            else if (r < 15) len = $urandom_range(TIMEOUT + 10, TIMEOUT + 30);
            else             len = $urandom_range(SETTLE + 3, 30);
            dgt = $urandom_range(0, 9);
            seg = ($urandom_range(0, 99) < 85) ? seg_tab[dgt] : 7'($urandom_range(0, 127));
            pre_len = 0;
            pre_seg = 7'd0;
            if (len > SETTLE && $urandom_range(0, 99) < 20) begin
                pre_len = $urandom_range(1, SETTLE - 2);
                pre_seg = 7'($urandom_range(0, 127));
            end
            drive_phase(seg, len, pre_seg, pre_len);
        end

        // 6: reset in the middle of a tens phase, then error-count saturation.
        phase(2, 20);
        phase(3, 4);
        reset_dut("reset_mid");
        for (int n = 0; n < 260; n++) begin
            drive_phase(7'b1111110, SETTLE + 3, 7'd0, 0);
        end
        phase(1, 20);
        check_levels("final");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        repeat (80000) @(posedge clk);
        n_fail++;
        $display("FAIL watchdog got=%0d exp=<80000 cycles", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
